// File: rtl/timer_count_unit_if.sv
// -----------------------------------------------------------------------------
// timer_count_unit_if
//   Bundles the CPU-side and run-control signals of timer_count_unit.
//   master : drives count_en, mode, the byte write port, tf_clr, irq_ack
//            (and cap_stb when TCU_CAPTURE_EN is defined).
//   slave  : the count unit; drives tl, th, tf, irq, ovf_pulse
//            (and cap_val when TCU_CAPTURE_EN is defined).
//   Optional feature macro: TCU_CAPTURE_EN (adds cap_stb / cap_val).
// -----------------------------------------------------------------------------
interface timer_count_unit_if;
    logic       count_en;
    logic [1:0] mode;
    logic       wr_en;
    logic       wr_sel;
    logic [7:0] wr_data;
    logic       tf_clr;
    logic       irq_ack;
    logic [7:0] tl;
    logic [7:0] th;
    logic       tf;
    logic       irq;
    logic       ovf_pulse;
`ifdef TCU_CAPTURE_EN
    logic        cap_stb;
    logic [15:0] cap_val;
`endif

    modport master (
        output count_en, mode, wr_en, wr_sel, wr_data, tf_clr, irq_ack,
`ifdef TCU_CAPTURE_EN
        output cap_stb,
        input  cap_val,
`endif
        input  tl, th, tf, irq, ovf_pulse
    );

    modport slave (
        input  count_en, mode, wr_en, wr_sel, wr_data, tf_clr, irq_ack,
`ifdef TCU_CAPTURE_EN
        input  cap_stb,
        output cap_val,
`endif
        output tl, th, tf, irq, ovf_pulse
    );
endinterface

// File: rtl/timer_count_unit.sv
// -----------------------------------------------------------------------------
// timer_count_unit
//   Count register stage of a classic 8051-style timer. Consumes the gated
//   count enable and advances TH/TL in one of four modes:
//     0 = 13-bit {th, tl[4:0]}, 1 = 16-bit {th, tl},
//     2 = 8-bit tl with auto-reload from th, 3 = hold.
//   Raises the sticky overflow flag tf (mirrored on irq) and a one-cycle
//   ovf_pulse. A CPU byte write loads th or tl and suppresses counting in
//   that cycle.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : timer_count_unit_if.slave (count_en, mode, wr_*, tf_clr,
//                irq_ack in; tl, th, tf, irq, ovf_pulse out)
// Parameters
//   TF_ACK_CLR : 1 = irq_ack also clears tf, 0 = only tf_clr clears tf
// Optional feature macro
//   TCU_CAPTURE_EN : adds cap_stb / cap_val snapshot of {th, tl}
// -----------------------------------------------------------------------------
module timer_count_unit #(
    parameter bit TF_ACK_CLR = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    timer_count_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_13BIT  = 2'd0,
        MODE_16BIT  = 2'd1,
        MODE_RELOAD = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    logic [7:0] tl_q, tl_d;
    logic [7:0] th_q, th_d;
    logic       tf_q, tf_d;
    logic       ovf_q, ovf_d;

    logic [12:0] cnt13;
    logic [15:0] cnt16;
    mode_e       mode;

    assign mode  = mode_e'(bus.mode);
    assign cnt13 = {th_q, tl_q[4:0]} + 13'd1;
    assign cnt16 = {th_q, tl_q} + 16'd1;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned; that is what keeps synthesis from inferring latches.
    always_comb begin
        tl_d  = tl_q;
        th_d  = th_q;
        ovf_d = 1'b0;
        if (bus.wr_en) begin
            // A CPU write owns the cycle: no increment, no overflow.
            if (bus.wr_sel) th_d = bus.wr_data;
            else            tl_d = bus.wr_data;
        end else if (bus.count_en) begin
            unique case (mode)
                MODE_13BIT: begin
                    // tl[7:5] are not part of the counter and keep their value.
                    tl_d  = {tl_q[7:5], cnt13[4:0]};
                    th_d  = cnt13[12:5];
                    ovf_d = (th_q == 8'hFF) && (tl_q[4:0] == 5'h1F);
                end
                MODE_16BIT: begin
                    {th_d, tl_d} = cnt16;
                    ovf_d        = (th_q == 8'hFF) && (tl_q == 8'hFF);
                end
                MODE_RELOAD: begin
                    if (tl_q == 8'hFF) begin
                        tl_d  = th_q;
                        ovf_d = 1'b1;
                    end else begin
                        tl_d  = tl_q + 8'd1;
                    end
                end
                MODE_HOLD: ;
                default: ;
            endcase
        end

        // Set has priority over any clear in the same cycle.
        if (ovf_d)
            tf_d = 1'b1;
        else if (bus.tf_clr || (TF_ACK_CLR && bus.irq_ack))
            tf_d = 1'b0;
        else
            tf_d = tf_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tl_q  <= 8'h00;
            th_q  <= 8'h00;
            tf_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            tl_q  <= tl_d;
            th_q  <= th_d;
            tf_q  <= tf_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.tl        = tl_q;
    assign bus.th        = th_q;
    assign bus.tf        = tf_q;
    assign bus.irq       = tf_q;
    assign bus.ovf_pulse = ovf_q;

`ifdef TCU_CAPTURE_EN
    logic [15:0] cap_q;

    // Captures the value held before this edge, so a coincident write or
    // increment does not leak into the snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cap_q <= 16'h0000;
        else if (bus.cap_stb) cap_q <= {th_q, tl_q};
    end

    assign bus.cap_val = cap_q;
`endif

endmodule
